// File: rtl/lut3_sweep_pkg.sv
// Shared types and constants for the 3-input truth-table sweep sequencer.
package lut3_sweep_pkg;

  localparam int N_IN = 3;
  localparam int TT_W = 8;

  // Reference table for a NAND3 cell: only vector 7 (all ones) drives a 0.
  localparam logic [TT_W-1:0] TT_NAND3 = 8'h7F;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DONE
  } sweep_state_t;

  // Width of a down-counter that must hold values 0 .. cycles-1 (at least 1 bit).
  function automatic int cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/lut3_sweep_ctrl_if.sv
// Host/gate-facing signal bundle of the sweep sequencer.
interface lut3_sweep_ctrl_if;
  import lut3_sweep_pkg::*;

  logic              start;
  logic              abort;
  logic [TT_W-1:0]   exp_table;
  logic [N_IN-1:0]   gate_in;
  logic              gate_out;
  logic              busy;
  logic              done;
  logic              pass;
  logic [TT_W-1:0]   cap_table;
  logic [TT_W-1:0]   mismatch;

  // Side that requests sweeps and hosts the gate under test.
  modport master (
    output start, abort, exp_table, gate_out,
    input  gate_in, busy, done, pass, cap_table, mismatch
  );

  // The sequencer itself.
  modport slave (
    input  start, abort, exp_table, gate_out,
    output gate_in, busy, done, pass, cap_table, mismatch
  );

endinterface

// File: rtl/lut3_sweep_ctrl_settle_timer.sv
// Loadable down-counter that paces how long each input vector is held.
module settle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Reload on request, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/lut3_sweep_ctrl.sv
// Drives vectors 0..7 into one 3-input gate, holds each for SETTLE_CYCLES,
// captures the gate output and compares it against a latched expected table.
module lut3_sweep_ctrl
  import lut3_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  lut3_sweep_ctrl_if.slave   bus
);

  localparam int              CNT_W  = cnt_width(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  sweep_state_t    r_state;
  sweep_state_t    w_next;
  logic [N_IN-1:0] r_idx;
  logic [TT_W-1:0] r_exp;
  logic [TT_W-1:0] r_cap;
  logic [TT_W-1:0] r_mismatch;
  logic            r_pass;

  logic            w_zero;
  logic            w_en;
  logic            w_load;
  logic            w_accept;
  logic            w_abort;
  logic            w_capture;
  logic            w_last;
  logic [TT_W-1:0] w_cap_next;

  assign w_en   = (r_state == SETTLE);
  assign w_last = &r_idx;

  settle_timer #(.W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_en       (w_en),
    .i_load_val (RELOAD),
    .o_zero     (w_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    w_next    = r_state;
    w_load    = 1'b0;
    w_accept  = 1'b0;
    w_abort   = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_load   = 1'b1;
          w_next   = SETTLE;
        end
      end
      SETTLE: begin
        if (bus.abort) begin
          w_abort = 1'b1;
          w_next  = IDLE;
        end else if (w_zero) begin
          w_capture = 1'b1;
          if (w_last) w_next = DONE;
          else        w_load = 1'b1;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Capture table with the current sample merged in, used for the final compare.
  always_comb begin
    w_cap_next        = r_cap;
    w_cap_next[r_idx] = bus.gate_out;
  end

  // Vector index, capture register and result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_exp      <= '0;
      r_cap      <= '0;
      r_mismatch <= '0;
      r_pass     <= 1'b0;
    end else if (w_accept) begin
      r_idx      <= '0;
      r_exp      <= bus.exp_table;
      r_cap      <= '0;
      r_mismatch <= '0;
      r_pass     <= 1'b0;
    end else if (w_abort) begin
      // Partial captures stay visible for debug; the verdict is withdrawn.
      r_mismatch <= '0;
      r_pass     <= 1'b0;
    end else if (w_capture) begin
      r_cap <= w_cap_next;
      if (w_last) begin
        r_pass     <= (w_cap_next == r_exp);
        r_mismatch <= w_cap_next ^ r_exp;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign bus.gate_in   = (r_state == SETTLE) ? r_idx : '0;
  assign bus.busy      = (r_state == SETTLE);
  assign bus.done      = (r_state == DONE);
  assign bus.pass      = r_pass;
  assign bus.cap_table = r_cap;
  assign bus.mismatch  = r_mismatch;

endmodule

// File: tb/tb_lut3_sweep_ctrl.sv
// Self-checking bench: three sequencers (S=4, S=1, S=3) each driving a
// behavioural gate; expected results are queued at start and scored on done.
module tb_lut3_sweep_ctrl;
  import lut3_sweep_pkg::*;

  typedef enum {G_NAND3, G_STUCK1, G_OR3, G_NAND3_DLY2} gkind_t;

  typedef struct {
    string      tag;
    logic [7:0] cap;
    logic [7:0] mis;
    logic       pass;
    int         done_cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lut3_sweep_ctrl_if if4 ();
  lut3_sweep_ctrl_if if1 ();
  lut3_sweep_ctrl_if if3 ();

  lut3_sweep_ctrl #(.SETTLE_CYCLES(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  lut3_sweep_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  lut3_sweep_ctrl #(.SETTLE_CYCLES(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  gkind_t k4 = G_NAND3, k1 = G_NAND3, k3 = G_NAND3;
  logic [1:0] dl4 = 2'b11, dl1 = 2'b11, dl3 = 2'b11;
  exp_t q4[$], q1[$], q3[$];

  function automatic logic gate_fn(input gkind_t k, input logic [2:0] v);
    case (k)
      G_STUCK1: return 1'b1;
      G_OR3:    return |v;
      default:  return ~&v;
    endcase
  endfunction

  // Gate models; the delayed one is a two-flop pipeline behind a NAND3.
  always @(posedge clk) dl4 <= {dl4[0], gate_fn(k4, if4.gate_in)};
  always @(posedge clk) dl1 <= {dl1[0], gate_fn(k1, if1.gate_in)};
  always @(posedge clk) dl3 <= {dl3[0], gate_fn(k3, if3.gate_in)};
  assign if4.gate_out = (k4 == G_NAND3_DLY2) ? dl4[1] : gate_fn(k4, if4.gate_in);
  assign if1.gate_out = (k1 == G_NAND3_DLY2) ? dl1[1] : gate_fn(k1, if1.gate_in);
  assign if3.gate_out = (k3 == G_NAND3_DLY2) ? dl3[1] : gate_fn(k3, if3.gate_in);

  // Expected capture: vector i is sampled at the end of cycle (i+1)*S after T;
  // a delayed gate shows the vector that was driven 'delay' cycles earlier.
  function automatic logic [7:0] model_cap(input gkind_t k, input int s);
    logic [7:0] cap;
    int         c;
    logic [2:0] v;
    for (int i = 0; i < 8; i++) begin
      c = (i + 1) * s;
      if (k == G_NAND3_DLY2) c = c - 2;
      v = (c >= 1 && c <= 8 * s) ? 3'((c - 1) / s) : 3'd0;
      cap[i] = gate_fn(k, v);
    end
    return cap;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int settle_of(input int d);
    return d;
  endfunction

  task automatic push(input int d, input string tag, input gkind_t k,
                      input logic [7:0] ex, input int t);
    exp_t e;
    e.tag      = tag;
    e.cap      = model_cap(k, settle_of(d));
    e.mis      = e.cap ^ ex;
    e.pass     = (e.cap == ex);
    e.done_cyc = t + 8 * settle_of(d) + 1;
    case (d)
      4:       q4.push_back(e);
      1:       q1.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  task automatic score(input int d, input logic dn, input logic [7:0] cap,
                       input logic [7:0] mis, input logic ps);
    exp_t e;
    bit   have = 0;
    case (d)
      4:       if (q4.size() > 0) begin e = q4.pop_front(); have = 1; end
      1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1; end
      default: if (q3.size() > 0) begin e = q3.pop_front(); have = 1; end
    endcase
    if (!have) begin
      check($sformatf("dut%0d unexpected done", d), 32'(dn), 0);
      return;
    end
    check({e.tag, " done cycle"}, cyc, e.done_cyc);
    check({e.tag, " cap_table"}, 32'(cap), 32'(e.cap));
    check({e.tag, " mismatch"}, 32'(mis), 32'(e.mis));
    check({e.tag, " pass"}, 32'(ps), 32'(e.pass));
  endtask

  always @(negedge clk) if (if4.done === 1'b1) score(4, if4.done, if4.cap_table, if4.mismatch, if4.pass);
  always @(negedge clk) if (if1.done === 1'b1) score(1, if1.done, if1.cap_table, if1.mismatch, if1.pass);
  always @(negedge clk) if (if3.done === 1'b1) score(3, if3.done, if3.cap_table, if3.mismatch, if3.pass);

  task automatic chk_outs(input int d, input string tag, input logic [2:0] gi_e,
                          input logic busy_e, input logic [7:0] cap_e,
                          input logic [7:0] mis_e, input logic pass_e, input logic done_e);
    logic [2:0] gi; logic bz, dn, ps; logic [7:0] cp, ms;
    case (d)
      4: begin gi = if4.gate_in; bz = if4.busy; dn = if4.done; ps = if4.pass; cp = if4.cap_table; ms = if4.mismatch; end
      1: begin gi = if1.gate_in; bz = if1.busy; dn = if1.done; ps = if1.pass; cp = if1.cap_table; ms = if1.mismatch; end
      default: begin gi = if3.gate_in; bz = if3.busy; dn = if3.done; ps = if3.pass; cp = if3.cap_table; ms = if3.mismatch; end
    endcase
    check({tag, " gate_in"}, 32'(gi), 32'(gi_e));
    check({tag, " busy"}, 32'(bz), 32'(busy_e));
    check({tag, " done"}, 32'(dn), 32'(done_e));
    check({tag, " pass"}, 32'(ps), 32'(pass_e));
    check({tag, " cap_table"}, 32'(cp), 32'(cap_e));
    check({tag, " mismatch"}, 32'(ms), 32'(mis_e));
  endtask

  // Selects a gate, idles a few cycles so a delayed gate flushes, then pulses
  // start for one cycle. Returns T; ends at the negedge of cycle T+1.
  task automatic start_on(input int d, input gkind_t k, input logic [7:0] ex,
                          input string tag, input bit expect_done,
                          input bit with_abort, output int t);
    @(negedge clk);
    case (d)
      4: begin k4 = k; if4.exp_table = ex; end
      1: begin k1 = k; if1.exp_table = ex; end
      default: begin k3 = k; if3.exp_table = ex; end
    endcase
    repeat (3) @(negedge clk);
    t = cyc;
    case (d)
      4: begin if4.start = 1'b1; if4.abort = with_abort; end
      1: begin if1.start = 1'b1; if1.abort = with_abort; end
      default: begin if3.start = 1'b1; if3.abort = with_abort; end
    endcase
    if (expect_done) push(d, tag, k, ex, t);
    @(negedge clk);
    case (d)
      4: begin if4.start = 1'b0; if4.abort = 1'b0; end
      1: begin if1.start = 1'b0; if1.abort = 1'b0; end
      default: begin if3.start = 1'b0; if3.abort = 1'b0; end
    endcase
  endtask

  task automatic wait_idle(input int d, input string tag);
    int left;
    int budget = 120;
    for (int i = 0; i < budget; i++) begin
      left = (d == 4) ? q4.size() : (d == 1) ? q1.size() : q3.size();
      if (left == 0) break;
      @(negedge clk);
    end
    left = (d == 4) ? q4.size() : (d == 1) ? q1.size() : q3.size();
    if (left != 0) check({tag, " timeout pending results"}, left, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    int t;
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    {if4.start, if4.abort, if4.exp_table} = '0;
    {if1.start, if1.abort, if1.exp_table} = '0;
    {if3.start, if3.abort, if3.exp_table} = '0;
    #1 rst_n = 1'b0;
    #20;
    chk_outs(4, "reset dut4", 3'd0, 0, 8'h00, 8'h00, 0, 0);
    chk_outs(1, "reset dut1", 3'd0, 0, 8'h00, 8'h00, 0, 0);
    chk_outs(3, "reset dut3", 3'd0, 0, 8'h00, 8'h00, 0, 0);
    @(negedge clk) rst_n = 1'b1;

    // NAND3 sweep with per-cycle vector/busy tracking.
    start_on(4, G_NAND3, TT_NAND3, "nand3 s4", 1, 0, t);
    while (cyc <= t + 32) begin
      check($sformatf("nand3 s4 busy c%0d", cyc - t), 32'(if4.busy), 1);
      check($sformatf("nand3 s4 gate_in c%0d", cyc - t), 32'(if4.gate_in), (cyc - t - 1) / 4);
      @(negedge clk);
    end
    check("nand3 s4 busy in done cycle", 32'(if4.busy), 0);
    check("nand3 s4 gate_in in done cycle", 32'(if4.gate_in), 0);
    wait_idle(4, "nand3 s4");

    // Stuck-at-1 gate against the NAND3 expectation.
    start_on(4, G_STUCK1, TT_NAND3, "stuck1 s4", 1, 0, t);
    wait_idle(4, "stuck1 s4");

    // Abort while vector 3 is driven; bits 2:0 of NAND3 (all ones) stay captured.
    start_on(4, G_NAND3, TT_NAND3, "abort s4", 0, 0, t);
    wait_cyc(t + 14);
    if4.abort = 1'b1;
    @(negedge clk);
    if4.abort = 1'b0;
    chk_outs(4, "after abort", 3'd0, 0, 8'h07, 8'h00, 0, 0);
    // Start and abort together in IDLE: start wins and the sweep completes.
    start_on(4, G_NAND3, TT_NAND3, "post-abort s4", 1, 1, t);
    wait_idle(4, "post-abort s4");

    // Start held high on S=1: back-to-back sweeps, mid-sweep pulse ignored.
    @(negedge clk);
    k1 = G_NAND3;
    if1.exp_table = TT_NAND3;
    repeat (2) @(negedge clk);
    t = cyc;
    if1.start = 1'b1;
    push(1, "held s1 #1", G_NAND3, TT_NAND3, t);
    push(1, "held s1 #2", G_NAND3, TT_NAND3, t + 10);
    wait_cyc(t + 9);
    check("held s1 busy in done cycle", 32'(if1.busy), 0);
    wait_cyc(t + 11);
    check("held s1 second sweep busy", 32'(if1.busy), 1);
    wait_cyc(t + 12);
    if1.start = 1'b0;
    wait_cyc(t + 14);
    if1.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    wait_idle(1, "held s1");
    repeat (4) @(negedge clk);

    // Asynchronous reset while vector 5 is driven.
    start_on(4, G_NAND3, TT_NAND3, "reset mid s4", 0, 0, t);
    wait_cyc(t + 22);
    check("pre-reset gate_in", 32'(if4.gate_in), 5);
    #1 rst_n = 1'b0;
    #1;
    chk_outs(4, "async reset", 3'd0, 0, 8'h00, 8'h00, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    start_on(4, G_OR3, 8'hFE, "or3 s4", 1, 0, t);
    wait_idle(4, "or3 s4");

    // Gate with a two-cycle output delay: too fast at S=1, fine at S=3.
    start_on(1, G_NAND3_DLY2, TT_NAND3, "dly2 s1", 1, 0, t);
    wait_idle(1, "dly2 s1");
    start_on(3, G_NAND3_DLY2, TT_NAND3, "dly2 s3", 1, 0, t);
    wait_idle(3, "dly2 s3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
